// File: rtl/sos_cascade_tdm.sv
// rtl/sos_cascade_tdm.sv - NSEC cascaded DF-I biquads for NCH TDM channels on one shared MAC
// One product per cycle: five MAC cycles plus one write-back cycle per section.
module sos_cascade_tdm #(
    parameter int WI   = 5,
    parameter int WF   = 11,
    parameter int NSEC = 2,
    parameter int NCH  = 4,
    localparam int W   = WI + WF,
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW  = $clog2(5 * NSEC)
) (
    input  logic                CLK,
    input  logic                nReset,
    input  logic signed [W-1:0] din,
    input  logic [CW-1:0]       din_ch,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [W-1:0] dout,
    output logic [CW-1:0]       dout_ch,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                coef_we,
    input  logic [AW-1:0]       coef_addr,
    input  logic signed [W-1:0] coef_data,
    input  logic                clr_state,
    output logic                ovf
);
    localparam int ACCW = 2 * W + 3;
    localparam int SW   = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int IW   = (NCH * NSEC > 1) ? $clog2(NCH * NSEC) : 1;
    localparam int NST  = 1 << IW;
    localparam int NCO  = 1 << AW;
    localparam logic signed [ACCW-1:0] YMAX = (ACCW'(1) <<< (W - 1)) - ACCW'(1);
    localparam logic signed [ACCW-1:0] YMIN = -YMAX - ACCW'(1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_OUT} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             k_q, k_d;
    logic [SW-1:0]          sec_q, sec_d;
    logic [CW-1:0]          ch_q, ch_d, dout_ch_q, dout_ch_d;
    logic signed [W-1:0]    x0_q, x0_d, dout_q, dout_d;
    logic signed [ACCW-1:0] acc_q, acc_d, rnd;
    logic                   ovf_q, ovf_d, ready_q;

    logic signed [W-1:0]    coef_q [NCO];
    logic signed [W-1:0]    x1_q [NST];
    logic signed [W-1:0]    x2_q [NST];
    logic signed [W-1:0]    y1_q [NST];
    logic signed [W-1:0]    y2_q [NST];

    logic [IW-1:0]          idx;
    logic [AW-1:0]          cidx;
    logic signed [W-1:0]    opnd, y_sat;
    logic signed [2*W-1:0]  prod;
    logic                   sat, clr, coef_wr, wb;

    assign out_valid = (state_q == S_OUT);
    assign in_ready  = ready_q && (state_q == S_IDLE) && !out_valid && !clr_state;
    assign dout      = dout_q;
    assign dout_ch   = dout_ch_q;
    assign ovf       = ovf_q;
    assign clr       = clr_state && (state_q == S_IDLE);
    assign coef_wr   = coef_we && (state_q == S_IDLE) && (int'(coef_addr) < 5 * NSEC);
    assign wb        = (state_q == S_WB);

    always_comb begin
        idx  = IW'(int'(ch_q) * NSEC + int'(sec_q));
        cidx = AW'(int'(sec_q) * 5 + int'(k_q));
        case (k_q)
            3'd0:    opnd = x0_q;
            3'd1:    opnd = x1_q[idx];
            3'd2:    opnd = x2_q[idx];
            3'd3:    opnd = y1_q[idx];
            default: opnd = y2_q[idx];
        endcase
        prod = (2 * W)'(coef_q[cidx]) * (2 * W)'(opnd);
        // Round half up, then clamp to the W-bit output range.
        rnd   = (acc_q + ACCW'(1 << (WF - 1))) >>> WF;
        sat   = 1'b0;
        y_sat = W'(rnd);
        if (rnd > YMAX) begin
            sat   = 1'b1;
            y_sat = W'(YMAX);
        end else if (rnd < YMIN) begin
            sat   = 1'b1;
            y_sat = W'(YMIN);
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        sec_d     = sec_q;
        ch_d      = ch_q;
        x0_d      = x0_q;
        acc_d     = acc_q;
        dout_d    = dout_q;
        dout_ch_d = dout_ch_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (clr) ovf_d = 1'b0;
                if (in_valid && in_ready) begin
                    state_d = S_MAC;
                    k_d     = 3'd0;
                    sec_d   = '0;
                    ch_d    = (int'(din_ch) >= NCH) ? CW'(NCH - 1) : din_ch;
                    x0_d    = din;
                end
            end
            S_MAC: begin
                if (k_q == 3'd0)      acc_d = ACCW'(prod);
                else if (k_q < 3'd3)  acc_d = acc_q + ACCW'(prod);
                else                  acc_d = acc_q - ACCW'(prod);
                if (k_q == 3'd4) begin
                    state_d = S_WB;
                    k_d     = 3'd0;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_WB: begin
                x0_d = y_sat;
                if (sat) ovf_d = 1'b1;
                if (sec_q == SW'(NSEC - 1)) begin
                    state_d   = S_OUT;
                    dout_d    = y_sat;
                    dout_ch_d = ch_q;
                end else begin
                    state_d = S_MAC;
                    sec_d   = sec_q + SW'(1);
                end
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            sec_q     <= '0;
            ch_q      <= '0;
            x0_q      <= '0;
            acc_q     <= '0;
            dout_q    <= '0;
            dout_ch_q <= '0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            sec_q     <= sec_d;
            ch_q      <= ch_d;
            x0_q      <= x0_d;
            acc_q     <= acc_d;
            dout_q    <= dout_d;
            dout_ch_q <= dout_ch_d;
            ovf_q     <= ovf_d;
            ready_q   <= 1'b1;
        end
    end

    // Each section resets to a unity-gain passthrough (b0 = 1.0).
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NCO; i++)
                coef_q[AW'(i)] <= ((i % 5 == 0) && (i < 5 * NSEC)) ? W'(1 << WF) : '0;
            for (int i = 0; i < NST; i++) begin
                x1_q[IW'(i)] <= '0;
                x2_q[IW'(i)] <= '0;
                y1_q[IW'(i)] <= '0;
                y2_q[IW'(i)] <= '0;
            end
        end else begin
            if (clr) begin
                for (int i = 0; i < NST; i++) begin
                    x1_q[IW'(i)] <= '0;
                    x2_q[IW'(i)] <= '0;
                    y1_q[IW'(i)] <= '0;
                    y2_q[IW'(i)] <= '0;
                end
            end else if (wb) begin
                x2_q[idx] <= x1_q[idx];
                x1_q[idx] <= x0_q;
                y2_q[idx] <= y1_q[idx];
                y1_q[idx] <= y_sat;
            end
            if (coef_wr) coef_q[coef_addr] <= coef_data;
        end
    end
endmodule

// File: tb/tb_sos_cascade_tdm.sv
// tb/tb_sos_cascade_tdm.sv - directed self-checking bench for sos_cascade_tdm
module tb_sos_cascade_tdm;
    logic        CLK = 1'b0;
    logic        nReset;
    logic [15:0] din;
    logic [1:0]  din_ch;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dout;
    logic [1:0]  dout_ch;
    logic        out_valid;
    logic        out_ready;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic        clr_state;
    logic        ovf;
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    always #5 CLK = ~CLK;

    sos_cascade_tdm dut (
        .CLK       (CLK),
        .nReset    (nReset),
        .din       (din),
        .din_ch    (din_ch),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .dout_ch   (dout_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .clr_state (clr_state),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] ch);
        int t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (t == 100) chk("send_ready_timeout", 32'(in_ready), 32'd1);
        din      = d;
        din_ch   = ch;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int t = 0;
        while (out_valid !== 1'b1 && t < 100) begin
            @(negedge CLK);
            t++;
        end
    endtask

    task automatic recv(input string tag, input logic [15:0] exp_d, input logic [1:0] exp_ch);
        wait_out();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_dout"}, 32'(dout), 32'(exp_d));
        chk({tag, "_ch"}, 32'(dout_ch), 32'(exp_ch));
        @(negedge CLK);
    endtask

    task automatic wcoef(input logic [3:0] a, input logic [15:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(negedge CLK);
        coef_we   = 1'b0;
    endtask

    task automatic clear();
        clr_state = 1'b1;
        #1 chk("clr_in_ready", 32'(in_ready), 32'd0);
        @(negedge CLK);
        clr_state = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic stable;
        nReset = 1'b0; din = '0; din_ch = '0; in_valid = 1'b0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; clr_state = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_ch", 32'(dout_ch), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        nReset = 1'b1;
        #1 chk("release_in_ready", 32'(in_ready), 32'd0);
        @(negedge CLK);
        chk("first_edge_in_ready", 32'(in_ready), 32'd1);

        // passthrough with exact latency; a coefficient write while busy must be ignored
        din = 16'h0400; din_ch = 2'd0; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        for (int i = 1; i <= 11; i++) begin
            coef_we = (i == 2);
            coef_addr = 4'd0;
            coef_data = 16'h0000;
            @(negedge CLK);
        end
        coef_we = 1'b0;
        chk("lat_e11_out_valid", 32'(out_valid), 32'd0);
        @(negedge CLK);
        chk("lat_e12_out_valid", 32'(out_valid), 32'd1);
        recv("pass", 16'h0400, 2'd0);
        chk("handshake_clears", 32'(out_valid), 32'd0);
        wcoef(4'd15, 16'h1234);
        send(16'hF800, 2'd3);
        recv("pass_neg", 16'hF800, 2'd3);

        // first-order impulse response on section 0
        wcoef(4'd0, 16'h0400);
        wcoef(4'd3, 16'hFC00);
        clear();
        send(16'h0800, 2'd0); recv("imp0", 16'h0400, 2'd0);
        send(16'h0000, 2'd0); recv("imp1", 16'h0200, 2'd0);
        send(16'h0000, 2'd0); recv("imp2", 16'h0100, 2'd0);
        chk("ovf_clean", 32'(ovf), 32'd0);

        // saturation, sticky overflow, clear
        wcoef(4'd3, 16'h0000);
        wcoef(4'd0, 16'h7FFF);
        send(16'h7FFF, 2'd2); recv("sat_pos", 16'h7FFF, 2'd2);
        chk("ovf_set", 32'(ovf), 32'd1);
        send(16'h8000, 2'd2); recv("sat_neg", 16'h8000, 2'd2);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        clear();
        chk("ovf_cleared", 32'(ovf), 32'd0);

        // channel isolation
        wcoef(4'd0, 16'h0400);
        wcoef(4'd3, 16'hFC00);
        clear();
        send(16'h0800, 2'd1); recv("iso_ch1a", 16'h0400, 2'd1);
        send(16'h0000, 2'd2); recv("iso_ch2", 16'h0000, 2'd2);
        send(16'h0000, 2'd1); recv("iso_ch1b", 16'h0200, 2'd1);

        // backpressure: output held, next sample waits
        clear();
        out_ready = 1'b0;
        send(16'h1000, 2'd0);
        wait_out();
        din = 16'h0800; din_ch = 2'd3; in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (dout !== 16'h0800 || dout_ch !== 2'd0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        @(negedge CLK);
        chk("bp_release", 32'(out_valid), 32'd0);
        @(negedge CLK);
        in_valid = 1'b0;
        recv("bp_second", 16'h0400, 2'd3);

        // reset mid-computation restores passthrough coefficients
        send(16'h0800, 2'd0);
        repeat (2) @(negedge CLK);
        nReset = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge CLK);
        nReset = 1'b1;
        @(negedge CLK);
        send(16'h0123, 2'd1);
        recv("post_rst", 16'h0123, 2'd1);

        if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
